// File: rtl/proc_seq_pkg.sv
// Shared types, condition-code encodings and the condition evaluator for the
// Procesador multi-cycle sequencer.
package proc_seq_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    SKIP   = 4'd3,
    EXEC   = 4'd4,
    MEM    = 4'd5,
    WB     = 4'd6,
    BRANCH = 4'd7,
    HALT   = 4'd8,
    ERROR  = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_HALT = 2'b11
  } op_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // flags = {N, Z, C, V}; the undefined encoding never passes
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Datapath and data-memory control bundle between the sequencer and the
// Procesador datapath.
interface proc_sequencer_if;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic        mem_ready;
  logic        ir_load;
  logic        pc_en;
  logic        branch;
  logic        rf_we;
  logic        wb_sel;
  logic        flags_we;
  logic        mem_req;
  logic        mem_we;

  modport master (
    input  instr, flags, mem_ready,
    output ir_load, pc_en, branch, rf_we, wb_sel, flags_we, mem_req, mem_we
  );

  modport slave (
    output instr, flags, mem_ready,
    input  ir_load, pc_en, branch, rf_we, wb_sel, flags_we, mem_req, mem_we
  );
endinterface

// File: rtl/proc_cond_eval.sv
// Combinational condition-code check of the instruction cond field against NZCV.
module proc_cond_eval
  import proc_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass,
  output logic       undef
);

  assign pass  = cond_pass(cond, flags);
  assign undef = (cond == COND_NV);

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle control FSM stepping each instruction through
// FETCH/DECODE/EXEC/MEM/WB and issuing datapath enables.
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  proc_sequencer_if.master     bus,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [CNT_W-1:0]     instr_count
);

  // Timeout counter only needs to reach MEM_TIMEOUT-1
  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cond_ok, cond_undef;
  op_t              op;
  logic             s_bit;
  logic             unused_instr;

  assign op           = op_t'(bus.instr[27:26]);
  assign s_bit        = bus.instr[20];
  assign unused_instr = ^{bus.instr[25:21], bus.instr[19:0]};

  proc_cond_eval u_cond (
    .cond  (bus.instr[31:28]),
    .flags (bus.flags),
    .pass  (cond_ok),
    .undef (cond_undef)
  );

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (cond_undef)   state_d = ERROR;
        else if (!cond_ok) state_d = SKIP;
        else begin
          case (op)
            OP_DP, OP_MEM: state_d = EXEC;
            OP_BR:         state_d = BRANCH;
            default:       state_d = HALT;
          endcase
        end
      end
      SKIP:   state_d = FETCH;
      EXEC:   state_d = (op == OP_MEM) ? MEM : FETCH;
      MEM: begin
        if (bus.mem_ready)                   state_d = s_bit ? WB : FETCH;
        else if (tcnt_q == TW'(MEM_TIMEOUT - 1)) state_d = ERROR;
      end
      WB, BRANCH:  state_d = FETCH;
      HALT, ERROR: state_d = state_q;
      default:     state_d = IDLE;
    endcase
  end

  // Output decode from state and instruction; a completing store also
  // advances the PC in its last MEM cycle, so pc_en there follows mem_ready
  always_comb begin
    bus.ir_load  = 1'b0;
    bus.pc_en    = 1'b0;
    bus.branch   = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = 1'b0;
    bus.flags_we = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    case (state_q)
      FETCH: bus.ir_load = 1'b1;
      SKIP:  bus.pc_en   = 1'b1;
      EXEC: begin
        if (op == OP_DP) begin
          bus.rf_we    = 1'b1;
          bus.flags_we = s_bit;
          bus.pc_en    = 1'b1;
        end
      end
      MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = !s_bit;
        bus.pc_en   = bus.mem_ready && !s_bit;
      end
      WB: begin
        bus.rf_we  = 1'b1;
        bus.wb_sel = 1'b1;
        bus.pc_en  = 1'b1;
      end
      BRANCH: begin
        bus.branch = 1'b1;
        bus.pc_en  = 1'b1;
      end
      default: ;
    endcase
    busy   = !(state_q inside {IDLE, HALT, ERROR});
    halted = (state_q == HALT);
    err    = (state_q == ERROR);
  end

  // Timeout restarts on every MEM entry; retired count follows pc_en
  always_comb begin
    tcnt_d  = (state_q == MEM && state_d == MEM) ? tcnt_q + TW'(1) : '0;
    count_d = bus.pc_en ? count_q + CNT_W'(1) : count_q;
  end

  // State, timeout and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: per-cycle expected outputs are queued
// with the stimulus and compared when the DUT reaches that cycle.
module tb_proc_sequencer;

  typedef logic [10:0] ovec_t;  // {ir_load,pc_en,branch,rf_we,wb_sel,flags_we,mem_req,mem_we,busy,halted,err}

  localparam ovec_t O_IDLE   = 11'b000_0000_0000;
  localparam ovec_t O_FETCH  = 11'b100_0000_0100;
  localparam ovec_t O_DECODE = 11'b000_0000_0100;
  localparam ovec_t O_SKIP   = 11'b010_0000_0100;
  localparam ovec_t O_EXDP   = 11'b010_1000_0100;
  localparam ovec_t O_EXMEM  = 11'b000_0000_0100;
  localparam ovec_t O_MEMLD  = 11'b000_0001_0100;
  localparam ovec_t O_MEMST  = 11'b000_0001_1100;
  localparam ovec_t O_STDONE = 11'b010_0001_1100;
  localparam ovec_t O_WB     = 11'b010_1100_0100;
  localparam ovec_t O_BRANCH = 11'b011_0000_0100;
  localparam ovec_t O_HALT   = 11'b000_0000_0010;
  localparam ovec_t O_ERR    = 11'b000_0000_0001;

  localparam logic [31:0] I_ADD  = 32'hE0810002;
  localparam logic [31:0] I_ADDEQ = 32'h00810002;
  localparam logic [31:0] I_LDR  = 32'hE4100000;
  localparam logic [31:0] I_STR  = 32'hE4000000;
  localparam logic [31:0] I_HALT = 32'hEC000000;
  localparam logic [31:0] I_UND  = 32'hF0000000;

  typedef struct {
    logic        st;
    logic        rdy;
    logic [31:0] ins;
    logic [3:0]  fl;
    ovec_t       o;
    logic [15:0] cnt;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instr = '0;
  logic [3:0]  flags = '0;
  logic        mem_ready = 1'b0;
  logic        busy, halted, err;
  logic [15:0] cnt;
  logic        busy4, halted4, err4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;
  sb_t sb[$];
  logic [15:0] exp_cnt = '0;

  proc_sequencer_if bus ();
  proc_sequencer_if bus4 ();

  assign bus.instr      = instr;
  assign bus.flags      = flags;
  assign bus.mem_ready  = mem_ready;
  assign bus4.instr     = instr;
  assign bus4.flags     = flags;
  assign bus4.mem_ready = mem_ready;

  proc_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .halted(halted), .err(err), .instr_count(cnt)
  );

  proc_sequencer #(.CNT_W(4), .MEM_TIMEOUT(15)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bus(bus4),
    .busy(busy4), .halted(halted4), .err(err4), .instr_count(cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ovec_t obs();
    return {bus.ir_load, bus.pc_en, bus.branch, bus.rf_we, bus.wb_sel, bus.flags_we,
            bus.mem_req, bus.mem_we, busy, halted, err};
  endfunction

  function automatic ovec_t obs4();
    return {bus4.ir_load, bus4.pc_en, bus4.branch, bus4.rf_we, bus4.wb_sel, bus4.flags_we,
            bus4.mem_req, bus4.mem_we, busy4, halted4, err4};
  endfunction

  // Expected count is the number of pc_en cycles before this one
  function automatic void push(logic st, logic rdy, logic [31:0] ins, logic [3:0] fl, ovec_t o);
    sb_t s;
    s.st = st; s.rdy = rdy; s.ins = ins; s.fl = fl; s.o = o; s.cnt = exp_cnt;
    sb.push_back(s);
    if (o[9]) exp_cnt = exp_cnt + 16'd1;
  endfunction

  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy & !z;
      4'h9: return !cy | z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z & (n == v);
      4'hD: return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (obs() !== O_IDLE) begin errors++; $display("FAIL reset_out: got %b want %b", obs(), O_IDLE); end
    checks++;
    if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    checks++;
    if (cnt4 !== 4'd0) begin errors++; $display("FAIL reset_cnt4: got %0d want 0", cnt4); end
    do_reset();
  endtask

  task automatic test_dp();
    sb_t s;
    do_reset();
    push(1, 0, I_ADD, 4'h0, O_IDLE);
    push(0, 0, I_ADD, 4'h0, O_FETCH);
    push(0, 0, I_ADD, 4'h0, O_DECODE);
    push(0, 0, I_ADD, 4'h0, O_EXDP);
    push(0, 0, I_ADD, 4'h0, O_FETCH);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      start = s.st; mem_ready = s.rdy; instr = s.ins; flags = s.fl;
      #1;
      checks++;
      if (obs() !== s.o) begin errors++; $display("FAIL dp_out: got %b want %b", obs(), s.o); end
      checks++;
      if (cnt !== s.cnt) begin errors++; $display("FAIL dp_cnt: got %0d want %0d", cnt, s.cnt); end
    end
  endtask

  task automatic test_cond();
    sb_t s;
    do_reset();
    push(1, 0, I_ADDEQ, 4'b0000, O_IDLE);
    push(0, 0, I_ADDEQ, 4'b0000, O_FETCH);
    push(0, 0, I_ADDEQ, 4'b0000, O_DECODE);
    push(0, 0, I_ADDEQ, 4'b0000, O_SKIP);
    push(0, 0, I_ADDEQ, 4'b0100, O_FETCH);
    push(0, 0, I_ADDEQ, 4'b0100, O_DECODE);
    push(0, 0, I_ADDEQ, 4'b0100, O_EXDP);
    push(0, 0, I_ADDEQ, 4'b0100, O_FETCH);
    // randomised sweep of the condition table, mixing DP and branch opcodes
    for (int unsigned i = 0; i < 40; i++) begin
      logic [3:0]  c, f;
      logic        br;
      logic [31:0] ins;
      c   = 4'($urandom_range(0, 14));
      f   = 4'($urandom_range(0, 15));
      br  = 1'($urandom_range(0, 1));
      ins = {c, (br ? 2'b10 : 2'b00), 26'h0};
      push(0, 0, ins, f, O_DECODE);
      push(0, 0, ins, f, !ref_cond(c, f) ? O_SKIP : (br ? O_BRANCH : O_EXDP));
      push(0, 0, ins, f, O_FETCH);
    end
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      start = s.st; mem_ready = s.rdy; instr = s.ins; flags = s.fl;
      #1;
      checks++;
      if (obs() !== s.o) begin errors++; $display("FAIL cond_out: instr %h flags %b got %b want %b", s.ins, s.fl, obs(), s.o); end
      checks++;
      if (cnt !== s.cnt) begin errors++; $display("FAIL cond_cnt: got %0d want %0d", cnt, s.cnt); end
    end
  endtask

  task automatic test_mem();
    sb_t s;
    do_reset();
    push(1, 0, I_LDR, 4'h0, O_IDLE);
    push(0, 0, I_LDR, 4'h0, O_FETCH);
    push(0, 1, I_LDR, 4'h0, O_DECODE);
    push(0, 1, I_LDR, 4'h0, O_EXMEM);
    push(0, 0, I_LDR, 4'h0, O_MEMLD);
    push(0, 1, I_LDR, 4'h0, O_MEMLD);
    push(0, 0, I_LDR, 4'h0, O_WB);
    push(0, 0, I_STR, 4'h0, O_FETCH);
    push(0, 0, I_STR, 4'h0, O_DECODE);
    push(0, 0, I_STR, 4'h0, O_EXMEM);
    push(0, 1, I_STR, 4'h0, O_STDONE);
    push(0, 0, I_STR, 4'h0, O_FETCH);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      start = s.st; mem_ready = s.rdy; instr = s.ins; flags = s.fl;
      #1;
      checks++;
      if (obs() !== s.o) begin errors++; $display("FAIL mem_out: got %b want %b", obs(), s.o); end
      checks++;
      if (cnt !== s.cnt) begin errors++; $display("FAIL mem_cnt: got %0d want %0d", cnt, s.cnt); end
    end
  endtask

  task automatic test_timeout();
    sb_t s;
    do_reset();
    push(1, 0, I_STR, 4'h0, O_IDLE);
    push(0, 0, I_STR, 4'h0, O_FETCH);
    push(0, 0, I_STR, 4'h0, O_DECODE);
    push(0, 0, I_STR, 4'h0, O_EXMEM);
    for (int unsigned i = 0; i < 15; i++) push(0, 0, I_STR, 4'h0, O_MEMST);
    push(0, 0, I_STR, 4'h0, O_ERR);
    push(1, 1, I_STR, 4'h0, O_ERR);
    push(0, 0, I_STR, 4'h0, O_ERR);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      start = s.st; mem_ready = s.rdy; instr = s.ins; flags = s.fl;
      #1;
      checks++;
      if (obs() !== s.o) begin errors++; $display("FAIL timeout_out: got %b want %b", obs(), s.o); end
      checks++;
      if (cnt !== s.cnt) begin errors++; $display("FAIL timeout_cnt: got %0d want %0d", cnt, s.cnt); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (obs() !== O_IDLE) begin errors++; $display("FAIL timeout_rst: got %b want %b", obs(), O_IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_halt();
    sb_t s;
    do_reset();
    push(1, 0, I_HALT, 4'h0, O_IDLE);
    push(0, 0, I_HALT, 4'h0, O_FETCH);
    push(0, 0, I_HALT, 4'h0, O_DECODE);
    push(1, 0, I_HALT, 4'h0, O_HALT);
    push(1, 1, I_HALT, 4'h0, O_HALT);
    push(0, 0, I_HALT, 4'h0, O_HALT);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      start = s.st; mem_ready = s.rdy; instr = s.ins; flags = s.fl;
      #1;
      checks++;
      if (obs() !== s.o) begin errors++; $display("FAIL halt_out: got %b want %b", obs(), s.o); end
    end
    do_reset();
    push(1, 0, I_UND, 4'hF, O_IDLE);
    push(0, 0, I_UND, 4'hF, O_FETCH);
    push(0, 0, I_UND, 4'hF, O_DECODE);
    push(0, 0, I_UND, 4'hF, O_ERR);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      start = s.st; mem_ready = s.rdy; instr = s.ins; flags = s.fl;
      #1;
      checks++;
      if (obs() !== s.o) begin errors++; $display("FAIL undef_out: got %b want %b", obs(), s.o); end
    end
  endtask

  task automatic test_wrap();
    sb_t s;
    do_reset();
    push(1, 0, I_ADD, 4'h0, O_IDLE);
    for (int unsigned i = 0; i < 16; i++) begin
      push(0, 0, I_ADD, 4'h0, O_FETCH);
      push(0, 0, I_ADD, 4'h0, O_DECODE);
      push(0, 0, I_ADD, 4'h0, O_EXDP);
    end
    push(0, 0, I_ADD, 4'h0, O_FETCH);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      start = s.st; mem_ready = s.rdy; instr = s.ins; flags = s.fl;
      #1;
      checks++;
      if (obs4() !== s.o) begin errors++; $display("FAIL wrap_out: got %b want %b", obs4(), s.o); end
      checks++;
      if (cnt4 !== s.cnt[3:0]) begin errors++; $display("FAIL wrap_cnt4: got %0d want %0d", cnt4, s.cnt[3:0]); end
    end
    checks++;
    if (cnt4 !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", cnt4); end
    checks++;
    if (cnt !== 16'd16) begin errors++; $display("FAIL wrap_cnt16: got %0d want 16", cnt); end
  endtask

  task automatic test_rst_in_mem();
    sb_t s;
    do_reset();
    push(1, 0, I_LDR, 4'h0, O_IDLE);
    push(0, 0, I_LDR, 4'h0, O_FETCH);
    push(0, 0, I_LDR, 4'h0, O_DECODE);
    push(0, 0, I_LDR, 4'h0, O_EXMEM);
    push(0, 0, I_LDR, 4'h0, O_MEMLD);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      start = s.st; mem_ready = s.rdy; instr = s.ins; flags = s.fl;
      #1;
      checks++;
      if (obs4() !== s.o) begin errors++; $display("FAIL rstmem_out: got %b want %b", obs4(), s.o); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus4.mem_req !== 1'b1) begin errors++; $display("FAIL rstmem_pre: mem_req got %b want 1", bus4.mem_req); end
    @(negedge clk); #1;
    checks++;
    if (obs4() !== O_IDLE) begin errors++; $display("FAIL rstmem_idle: got %b want %b", obs4(), O_IDLE); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dp();
    test_cond();
    test_mem();
    test_timeout();
    test_halt();
    test_wrap();
    test_rst_in_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
